// File: rtl/sar_pkg.sv
// Shared types for the SAR scan controller: FSM state encoding and channel-select width helper.
// Pure declarations; no logic, no latency, no flow control.
package sar_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE   = 2'd0,
        SAMPLE = 2'd1,
        CONV   = 2'd2,
        DONE   = 2'd3
    } state_t;

    // A single-input mux still needs a one-bit select port.
    function automatic int ch_width(input int channels);
        return (channels <= 1) ? 1 : $clog2(channels);
    endfunction

endpackage

// File: rtl/sar_bit_engine.sv
// Successive-approximation bit search: start loads an empty trial and MSB mask, each step resolves one bit.
// WIDTH steps per code; done flags the final step, where code carries the finished result; no backpressure.
module sar_bit_engine #(
    parameter int WIDTH = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             step,
    input  logic             cmp,
    output logic [WIDTH-1:0] value,
    output logic [WIDTH-1:0] code,
    output logic             done
);

    localparam logic [WIDTH-1:0] MSB = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH-1:0] trial;
    logic [WIDTH-1:0] mask;

    always_ff @(posedge clk) begin
        if (rst) begin
            trial <= '0;
            mask  <= '0;
        end else if (start) begin
            trial <= '0;
            mask  <= MSB;
        end else if (step) begin
            if (cmp) begin
                trial <= trial | mask;
            end
            mask <= mask >> 1;
        end
    end

    // The comparator answers for the current trial within the cycle, so the
    // last decision is folded into code combinationally rather than waiting a cycle.
    always_comb begin
        value = step ? (trial | mask) : '0;
        code  = cmp ? (trial | mask) : trial;
        done  = step && mask[0];
    end

endmodule

// File: rtl/sar_scan_controller.sv
// Multi-channel SAR ADC sequencer: scans enabled channels, averages 2^AVG_LOG2 codes each, one-shot or continuous.
// 2^AVG_LOG2*(SAMPLE_CYCLES+WIDTH)+1 cycles per channel; go is ignored while busy, results are not back-pressured.
module sar_scan_controller
    import sar_pkg::*;
#(
    parameter int WIDTH         = 12,
    parameter int CHANNELS      = 4,
    parameter int AVG_LOG2      = 0,
    parameter int SAMPLE_CYCLES = 2,
    localparam int CH_W         = ch_width(CHANNELS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                go,
    input  logic                continuous,
    input  logic [CHANNELS-1:0] ch_en,
    input  logic                cmp,
    output logic                sample,
    output logic [CH_W-1:0]     mux_sel,
    output logic [WIDTH-1:0]    value,
    output logic                valid,
    output logic [WIDTH-1:0]    result,
    output logic [CH_W-1:0]     result_ch,
    output logic                busy
);

    localparam int REPS   = 1 << AVG_LOG2;
    localparam int ACC_W  = WIDTH + AVG_LOG2;
    localparam int REP_W  = AVG_LOG2 + 1;
    localparam int SCNT_W = $clog2(SAMPLE_CYCLES + 1);

    state_t state;
    state_t state_next;

    logic [CHANNELS-1:0] scan_mask;
    logic [ACC_W-1:0]    acc;
    logic [ACC_W-1:0]    acc_sum;
    logic [ACC_W-1:0]    acc_avg;
    logic [REP_W-1:0]    rep;
    logic [SCNT_W-1:0]   scnt;

    logic             eng_start;
    logic             eng_step;
    logic             eng_done;
    logic [WIDTH-1:0] eng_code;

    logic             latch_mask;
    logic             ch_load;
    logic             clear_acc;
    logic [CH_W-1:0]  ch_target;
    logic             rep_last;
    logic             sample_last;

    logic [CH_W-1:0]  en_low;
    logic [CH_W-1:0]  mask_low;
    logic [CH_W-1:0]  next_idx;
    logic             have_next;

    sar_bit_engine #(
        .WIDTH (WIDTH)
    ) u_engine (
        .clk   (clk),
        .rst   (rst),
        .start (eng_start),
        .step  (eng_step),
        .cmp   (cmp),
        .value (value),
        .code  (eng_code),
        .done  (eng_done)
    );

    // Channel pickers: descending loops so the lowest qualifying index wins.
    always_comb begin
        en_low    = '0;
        mask_low  = '0;
        next_idx  = '0;
        have_next = 1'b0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (ch_en[i]) begin
                en_low = CH_W'(i);
            end
            if (scan_mask[i]) begin
                mask_low = CH_W'(i);
            end
            if (scan_mask[i] && (i > int'(mux_sel))) begin
                next_idx  = CH_W'(i);
                have_next = 1'b1;
            end
        end
    end

    assign rep_last    = (rep == REP_W'(REPS - 1));
    assign sample_last = (scnt == SCNT_W'(SAMPLE_CYCLES - 1));
    assign acc_sum     = acc + ACC_W'(eng_code);
    assign acc_avg     = acc_sum >> AVG_LOG2;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        sample     = 1'b0;
        valid      = 1'b0;
        busy       = 1'b1;
        eng_start  = 1'b0;
        eng_step   = 1'b0;
        latch_mask = 1'b0;
        ch_load    = 1'b0;
        clear_acc  = 1'b0;
        ch_target  = '0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (go && (ch_en != '0)) begin
                    state_next = SAMPLE;
                    latch_mask = 1'b1;
                    ch_load    = 1'b1;
                    ch_target  = en_low;
                    clear_acc  = 1'b1;
                end
            end
            SAMPLE: begin
                sample    = 1'b1;
                eng_start = 1'b1;
                if (sample_last) begin
                    state_next = CONV;
                end
            end
            CONV: begin
                eng_step = 1'b1;
                if (eng_done) begin
                    state_next = rep_last ? DONE : SAMPLE;
                end
            end
            DONE: begin
                valid = 1'b1;
                if (have_next) begin
                    state_next = SAMPLE;
                    ch_load    = 1'b1;
                    ch_target  = next_idx;
                    clear_acc  = 1'b1;
                end else if (continuous) begin
                    state_next = SAMPLE;
                    ch_load    = 1'b1;
                    ch_target  = mask_low;
                    clear_acc  = 1'b1;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            scan_mask <= '0;
            mux_sel   <= '0;
            acc       <= '0;
            rep       <= '0;
            scnt      <= '0;
            result    <= '0;
            result_ch <= '0;
        end else begin
            if (latch_mask) begin
                scan_mask <= ch_en;
            end
            if (ch_load) begin
                mux_sel <= ch_target;
            end
            if (state == SAMPLE) begin
                scnt <= sample_last ? '0 : scnt + 1'b1;
            end else begin
                scnt <= '0;
            end
            if (clear_acc) begin
                acc <= '0;
                rep <= '0;
            end else if (eng_done) begin
                acc <= acc_sum;
                rep <= rep + 1'b1;
                if (rep_last) begin
                    result    <= acc_avg[WIDTH-1:0];
                    result_ch <= mux_sel;
                end
            end
        end
    end

endmodule

// File: tb/tb_sar_scan_controller.sv
// Directed bench for sar_scan_controller: default instance plus a 4x-averaging instance,
// both driven by behavioural comparators holding per-channel analogue levels.
module tb_sar_scan_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        go;
    logic        continuous;
    logic [3:0]  ch_en;
    logic        cmp;
    logic        sample;
    logic [1:0]  mux_sel;
    logic [11:0] value;
    logic        valid;
    logic [11:0] result;
    logic [1:0]  result_ch;
    logic        busy;

    logic        go_b;
    logic [3:0]  ch_en_b;
    logic        cmp_b;
    logic        sample_b;
    logic [1:0]  mux_sel_b;
    logic [11:0] value_b;
    logic        valid_b;
    logic [11:0] result_b;
    logic [1:0]  result_ch_b;
    logic        busy_b;

    logic [11:0] hold [4];
    logic [11:0] hold_b;

    sar_scan_controller dut (
        .clk        (clk),
        .rst        (rst),
        .go         (go),
        .continuous (continuous),
        .ch_en      (ch_en),
        .cmp        (cmp),
        .sample     (sample),
        .mux_sel    (mux_sel),
        .value      (value),
        .valid      (valid),
        .result     (result),
        .result_ch  (result_ch),
        .busy       (busy)
    );

    sar_scan_controller #(
        .AVG_LOG2 (2)
    ) dut_avg (
        .clk        (clk),
        .rst        (rst),
        .go         (go_b),
        .continuous (1'b0),
        .ch_en      (ch_en_b),
        .cmp        (cmp_b),
        .sample     (sample_b),
        .mux_sel    (mux_sel_b),
        .value      (value_b),
        .valid      (valid_b),
        .result     (result_b),
        .result_ch  (result_ch_b),
        .busy       (busy_b)
    );

    assign cmp   = (hold[mux_sel] >= value);
    assign cmp_b = (hold_b >= value_b);

    int   cyc = 0;
    int   checks = 0;
    int   passes = 0;
    int   last_t = 0;
    int   conv_b = 0;
    int   valid_cnt = 0;
    logic sample_b_q = 1'b0;
    logic watch_mux = 1'b0;
    logic bad_mux = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Averaging instance sees 0x100 and 0x103 on alternate conversions.
    assign hold_b = conv_b[0] ? 12'h100 : 12'h103;
    always @(negedge clk) begin
        if (sample_b && !sample_b_q) conv_b = conv_b + 1;
        sample_b_q = sample_b;
        if (valid) valid_cnt = valid_cnt + 1;
        if (watch_mux && busy && (mux_sel == 2'd0 || mux_sel == 2'd2)) bad_mux = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) passes++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    endtask

    task automatic pulse_go();
        last_t = cyc;
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
    endtask

    task automatic expect_valid(input string tag, input logic [31:0] exp_ch,
                                input logic [31:0] exp_res, input int exp_delta);
        int t0;
        t0 = cyc;
        while (valid !== 1'b1 && (cyc - t0) < 200) @(negedge clk);
        check({tag, " valid"}, 32'(valid), 32'd1);
        check({tag, " delta"}, 32'(cyc - last_t), 32'(exp_delta));
        check({tag, " ch"}, 32'(result_ch), exp_ch);
        check({tag, " result"}, 32'(result), exp_res);
        last_t = cyc;
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, required finish");
        $fatal(1);
    end

    initial begin
        int t0;
        rst = 1'b1; go = 1'b0; continuous = 1'b0; ch_en = 4'h0;
        go_b = 1'b0; ch_en_b = 4'h0;
        for (int i = 0; i < 4; i++) hold[i] = 12'h000;
        repeat (3) @(negedge clk);

        check("rst sample", 32'(sample), 0);
        check("rst mux_sel", 32'(mux_sel), 0);
        check("rst value", 32'(value), 0);
        check("rst valid", 32'(valid), 0);
        check("rst result", 32'(result), 0);
        check("rst result_ch", 32'(result_ch), 0);
        check("rst busy", 32'(busy), 0);
        check("rst busy_avg", 32'(busy_b), 0);
        rst = 1'b0;
        @(negedge clk);

        // Single channel one-shot.
        hold[0] = 12'h467; ch_en = 4'b0001;
        pulse_go();
        check("t1 sample after go", 32'(sample), 1);
        check("t1 busy", 32'(busy), 1);
        expect_valid("t1", 0, 32'h467, 15);
        check("t1 idle busy", 32'(busy), 0);
        check("t1 idle valid", 32'(valid), 0);
        check("t1 idle value", 32'(value), 0);

        // Sparse mask: only channels 1 and 3.
        hold[1] = 12'hFFF; hold[3] = 12'h000; ch_en = 4'b1010;
        watch_mux = 1'b1;
        pulse_go();
        expect_valid("t2 ch1", 1, 32'hFFF, 15);
        expect_valid("t2 ch3", 3, 32'h000, 15);
        check("t2 idle busy", 32'(busy), 0);
        check("t2 mux skip", 32'(bad_mux), 0);
        watch_mux = 1'b0;

        // Averaging instance: 0x100,0x103,0x100,0x103 -> 0x406>>2.
        ch_en_b = 4'b0001;
        t0 = cyc;
        go_b = 1'b1;
        @(negedge clk);
        go_b = 1'b0;
        while (valid_b !== 1'b1 && (cyc - t0) < 300) @(negedge clk);
        check("t3 valid", 32'(valid_b), 1);
        check("t3 delta", 32'(cyc - t0), 57);
        check("t3 result", 32'(result_b), 32'h101);
        check("t3 ch", 32'(result_ch_b), 0);

        // Continuous scan with wrap, then continuous dropped and ch_en changed mid-scan.
        hold[0] = 12'h123; hold[1] = 12'h456; hold[2] = 12'h789; hold[3] = 12'hABC;
        ch_en = 4'b1111; continuous = 1'b1;
        pulse_go();
        expect_valid("t4 s1 ch0", 0, 32'h123, 15);
        expect_valid("t4 s1 ch1", 1, 32'h456, 15);
        expect_valid("t4 s1 ch2", 2, 32'h789, 15);
        expect_valid("t4 s1 ch3", 3, 32'hABC, 15);
        expect_valid("t4 s2 ch0", 0, 32'h123, 15);
        continuous = 1'b0; ch_en = 4'b0001;
        expect_valid("t4 s2 ch1", 1, 32'h456, 15);
        expect_valid("t4 s2 ch2", 2, 32'h789, 15);
        expect_valid("t4 s2 ch3", 3, 32'hABC, 15);
        check("t4 idle busy", 32'(busy), 0);

        // Reset while resolving bit 5 of 0xA5A.
        hold[0] = 12'hA5A;
        pulse_go();
        repeat (8) @(negedge clk);
        check("t5 trial bit5", 32'(value), 32'hA60);
        rst = 1'b1;
        @(negedge clk);
        check("t5 rst busy", 32'(busy), 0);
        check("t5 rst sample", 32'(sample), 0);
        check("t5 rst value", 32'(value), 0);
        check("t5 rst valid", 32'(valid), 0);
        check("t5 rst result", 32'(result), 0);
        check("t5 rst result_ch", 32'(result_ch), 0);
        rst = 1'b0;
        valid_cnt = 0;
        repeat (20) @(negedge clk);
        check("t5 no valid", 32'(valid_cnt), 0);
        check("t5 still idle", 32'(busy), 0);
        pulse_go();
        expect_valid("t5 restart", 0, 32'hA5A, 15);

        // go with empty mask is refused.
        ch_en = 4'b0000; go = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t6 empty busy", 32'(busy), 0);
            check("t6 empty sample", 32'(sample), 0);
        end

        // go held high through a scan: one IDLE cycle between scans.
        hold[0] = 12'h3C3; ch_en = 4'b0001;
        last_t = cyc;
        expect_valid("t6 held a", 0, 32'h3C3, 15);
        check("t6 idle gap", 32'(busy), 0);
        @(negedge clk);
        check("t6 reaccept", 32'(busy), 1);
        go = 1'b0;
        expect_valid("t6 held b", 0, 32'h3C3, 16);
        repeat (3) @(negedge clk);
        check("t6 final idle", 32'(busy), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/sar_scan_controller.md
# sar_scan_controller

Parametrised successor to the single-channel 8-bit SAR controller: drives the sample/hold switch, input mux select and DAC trial code of a successive-approximation ADC front end. It scans a programmable set of channels, optionally averages 2^AVG_LOG2 conversions per channel, and runs one-shot or continuous. It sits between the analogue comparator/DAC and the digital result consumer.

## Interface
- WIDTH, 12: conversion resolution in bits (≥2)
- CHANNELS, 4: number of mux inputs (≥1); CH_W = max(1, clog2(CHANNELS))
- AVG_LOG2, 0: log2 of conversions averaged per channel (0..4)
- SAMPLE_CYCLES, 2: cycles sample is held high per conversion (≥1)
- clk  in  1  clock; one clock domain, rising edge
- rst  in  1  synchronous, active-high reset
- go  in  1  start request, level-sensitive, honoured only in IDLE
- continuous  in  1  1 = restart scan after last channel; sampled at each scan end
- ch_en  in  CHANNELS  channel enable mask, latched when go is accepted
- cmp  in  1  comparator: 1 when held input ≥ DAC code on value
- sample  out  1  sample/hold switch closed
- mux_sel  out  CH_W  analogue mux channel
- value  out  WIDTH  DAC trial code
- valid  out  1  one-cycle pulse: result/result_ch valid
- result  out  WIDTH  final (averaged) code, held until next valid
- result_ch  out  CH_W  channel of result
- busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, SAMPLE, CONV, DONE.
- IDLE: go=1 and ch_en≠0 → latch ch_en into scan mask, mux_sel = lowest enabled channel, clear accumulator and rep counter → SAMPLE. go=1 with ch_en=0 → stay IDLE, no valid.
- SAMPLE: sample=1 for SAMPLE_CYCLES cycles; trial register cleared, bit mask = MSB → CONV.
- CONV: value = trial | mask. Each cycle: if cmp, trial |= mask; mask >>= 1. After WIDTH cycles, add trial to accumulator (WIDTH+AVG_LOG2 bits). If rep < 2^AVG_LOG2−1 → rep++, SAMPLE; else → DONE.
- DONE (1 cycle): valid=1, result = accumulator >> AVG_LOG2 (truncating), result_ch = mux_sel. Next: next higher enabled channel in latched mask → SAMPLE; none left and continuous=1 → lowest enabled channel, SAMPLE; else → IDLE.
- value = 0 outside CONV; sample = 0 outside SAMPLE.
- mux_sel changes only on exit from IDLE or DONE; stable through SAMPLE and CONV.
- go and ch_en changes while busy are ignored; continuous dropping mid-scan completes the current scan, then IDLE.

## Timing
- Reset values: state IDLE, sample 0, mux_sel 0, value 0, valid 0, result 0, result_ch 0, busy 0.
- rst mid-conversion: next cycle in reset state, no valid issued, partial accumulator discarded.
- go high at edge k → sample=1 from cycle k+1.
- Per channel: 2^AVG_LOG2 × (SAMPLE_CYCLES + WIDTH) + 1 cycles, DONE included; valid pulse in last.
- Default parameters: 15 cycles per channel; 4 enabled channels = 60 cycles per scan.
- cmp is sampled at the same edge value is updated; the comparator model must be combinational within one cycle.
- Continuous back-to-back: valid pulses exactly one conversion period apart, no idle cycle.

## Structure
- Package sar_pkg: state enum (IDLE, SAMPLE, CONV, DONE), state width localparam, CH_W function.
- Sub-module sar_bit_engine: trial/mask registers, WIDTH-cycle bit search, start/done handshake; the top holds the FSM, scan mask, channel selector, rep counter and accumulator.

## Test plan
- Defaults, ch_en=4'b0001, hold[0]=0x467, go pulse, continuous=0 → one valid at cycle 15 after go, result=0x467, result_ch=0, then IDLE, busy=0.
- ch_en=4'b1010, holds ch1=0xFFF, ch3=0x000 → valids in order ch1=0xFFF, ch3=0x000, 15 cycles apart; mux_sel never shows 0 or 2.
- AVG_LOG2=2, hold alternating 0x100/0x103 per conversion → result=0x101 (0x406>>2), valid after 4×14+1=57 cycles.
- continuous=1, ch_en=4'b1111, drop continuous mid-scan → scan completes with 4 valids ch0..3, then IDLE; ch_en changed mid-scan has no effect.
- rst asserted in CONV at trial bit 5 → all outputs at reset values next cycle, no valid; restart after go gives correct code.
- go with ch_en=0 → busy stays 0, no sample, no valid; go held high while busy → no extra scan until IDLE.
